serial_bcd_addsub: RTL and testbench

//  Multi-digit serial BCD adder/subtractor. Operands stream in least-significant beat first, DPC digits per beat.

---
 rtl/serial_bcd_addsub_if.sv | 27 ++
 rtl/serial_bcd_addsub.sv | 73 +++++++
 tb/tb_serial_bcd_addsub.sv | 122 ++++++++++++
 3 files changed

// File: rtl/serial_bcd_addsub_if.sv
// serial_bcd_addsub_if: framed operand/result bus of the serial BCD adder/subtractor
interface serial_bcd_addsub_if #(
  parameter int DPC   = 2,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_first;
  logic             in_last;
  logic             sub;
  logic [4*DPC-1:0] a;
  logic [4*DPC-1:0] b;
  logic             out_valid;
  logic             out_first;
  logic             out_last;
  logic [4*DPC-1:0] sum;
  logic [CNT_W-1:0] out_beat;
  logic             cout;
  logic             err;
  modport master (
    output in_valid, in_first, in_last, sub, a, b,
    input  out_valid, out_first, out_last, sum, out_beat, cout, err
  );
  modport slave (
    input  in_valid, in_first, in_last, sub, a, b,
    output out_valid, out_first, out_last, sum, out_beat, cout, err
  );
endinterface

// File: rtl/serial_bcd_addsub.sv
// serial_bcd_addsub: multi-digit serial BCD add/sub, LS beat first, DPC digits per beat
module serial_bcd_addsub #(
  parameter int DPC   = 2,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rstn,
  serial_bcd_addsub_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state_q, state_d;
  logic             accept, mode_q, mode_d, carry_q, err_q, bad;
  logic             valid_q, first_q, last_q;
  logic [4*DPC-1:0] sum_q, s;
  logic [CNT_W-1:0] beat_q, idx;
  logic [DPC:0]     c;
  logic [3:0]       ad [DPC];
  logic [3:0]       bv [DPC];
  logic [3:0]       bd [DPC];
  logic [4:0]       t  [DPC];
  // carry_q doubles as cout and beat_q as out_beat: both only change on a processed beat
  always_comb begin
    accept  = bus.in_valid & (bus.in_first | (state_q == BUSY));
    mode_d  = bus.in_first ? bus.sub : mode_q;
    c       = '0;
    c[0]    = bus.in_first ? bus.sub : carry_q;
    s       = '0;
    bad     = 1'b0;
    for (int i = 0; i < DPC; i++) begin
      ad[i]    = bus.a[4*i +: 4];
      bv[i]    = bus.b[4*i +: 4];
      bd[i]    = mode_d ? 4'(4'd9 - bv[i]) : bv[i];
      t[i]     = 5'(ad[i]) + 5'(bd[i]) + 5'(c[i]);
      c[i+1]   = t[i] > 5'd9;
      s[4*i +: 4] = c[i+1] ? 4'(t[i] + 5'd6) : t[i][3:0];
      bad      = bad | (ad[i] > 4'd9) | (bv[i] > 4'd9);
    end
    idx     = bus.in_first ? '0 : (&beat_q ? beat_q : beat_q + 1'b1);
    state_d = accept ? (bus.in_last ? IDLE : BUSY) : state_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      sum_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= accept;
      if (accept) begin
        mode_q  <= mode_d;
        carry_q <= c[DPC];
        err_q   <= bus.in_first ? bad : (err_q | bad);
        first_q <= bus.in_first;
        last_q  <= bus.in_last;
        sum_q   <= s;
        beat_q  <= idx;
      end
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_first = first_q;
  assign bus.out_last  = last_q;
  assign bus.sum       = sum_q;
  assign bus.out_beat  = beat_q;
  assign bus.cout      = carry_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_serial_bcd_addsub.sv
// tb_serial_bcd_addsub: directed vectors with a queue scoreboard and a negedge monitor
module tb_serial_bcd_addsub;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  typedef struct {
    logic [7:0] sum;
    logic       f;
    logic       l;
    logic [7:0] beat;
    logic       cout;
    logic       err;
  } exp_t;
  exp_t q[$];
  serial_bcd_addsub_if #(.DPC(2), .CNT_W(8)) bus ();
  serial_bcd_addsub #(.DPC(2), .CNT_W(8)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic f, input logic l,
                      input logic s, input logic push, input logic [7:0] es, input logic [7:0] eb,
                      input logic ec, input logic ee);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_first = f;
    bus.in_last  = l;
    bus.sub      = s;
    bus.a        = a;
    bus.b        = b;
    if (push) begin
      e.sum = es; e.f = f; e.l = l; e.beat = eb; e.cout = ec; e.err = ee;
      q.push_back(e);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask
  always @(negedge clk) begin
    if (rstn && bus.out_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat: got sum=%h beat=%0d, expected no output", bus.sum, bus.out_beat);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (!e.err) chk("sum", 32'(bus.sum), 32'(e.sum));
        chk("out_first", 32'(bus.out_first), 32'(e.f));
        chk("out_last", 32'(bus.out_last), 32'(e.l));
        chk("out_beat", 32'(bus.out_beat), 32'(e.beat));
        chk("err", 32'(bus.err), 32'(e.err));
        if (e.l) chk("cout", 32'(bus.cout), 32'(e.cout));
      end
    end
  end
  initial begin
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_sum", 32'(bus.sum), 0);
    chk("reset_cout", 32'(bus.cout), 0);
    #20;
    rstn = 1'b1;
    // single beat add
    send(8'h47, 8'h38, 1, 1, 0, 1, 8'h85, 8'd0, 0, 0);
    // ripple 9999+0001
    send(8'h99, 8'h01, 1, 0, 0, 1, 8'h00, 8'd0, 1, 0);
    send(8'h99, 8'h00, 0, 1, 0, 1, 8'h00, 8'd1, 1, 0);
    // 0100-0001 and 0005-0007
    send(8'h00, 8'h01, 1, 0, 1, 1, 8'h99, 8'd0, 0, 0);
    send(8'h01, 8'h00, 0, 1, 0, 1, 8'h00, 8'd1, 1, 0);
    send(8'h05, 8'h07, 1, 0, 1, 1, 8'h98, 8'd0, 0, 0);
    send(8'h00, 8'h00, 0, 1, 0, 1, 8'h99, 8'd1, 0, 0);
    // gap inside an operation
    send(8'h99, 8'h01, 1, 0, 0, 1, 8'h00, 8'd0, 1, 0);
    idle(3);
    send(8'h99, 8'h00, 0, 1, 0, 1, 8'h00, 8'd1, 1, 0);
    // abort: carry out of the first beat must not leak into the new op
    send(8'h99, 8'h01, 1, 0, 0, 1, 8'h00, 8'd0, 1, 0);
    send(8'h12, 8'h34, 1, 0, 0, 1, 8'h46, 8'd0, 0, 0);
    send(8'h00, 8'h00, 0, 1, 0, 1, 8'h00, 8'd1, 0, 0);
    // invalid digit, then clean op
    send(8'h3A, 8'h01, 1, 0, 0, 1, 8'h41, 8'd0, 0, 1);
    send(8'h00, 8'h00, 0, 1, 0, 1, 8'h00, 8'd1, 0, 1);
    send(8'h11, 8'h22, 1, 1, 0, 1, 8'h33, 8'd0, 0, 0);
    // reset between beats
    send(8'h12, 8'h34, 1, 0, 0, 1, 8'h46, 8'd0, 0, 0);
    idle(1);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_sum", 32'(bus.sum), 0);
    chk("rst_out_first", 32'(bus.out_first), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    send(8'h99, 8'h00, 0, 1, 0, 0, 8'h00, 8'd0, 0, 0);
    idle(3);
    send(8'h47, 8'h38, 1, 1, 0, 1, 8'h85, 8'd0, 0, 0);
    idle(4);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
